mem_access_ctrl: RTL

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl_pkg.sv | 22 ++
 rtl/mem_wait_counter.sv | 31 +++
 rtl/mem_access_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared widths, wait default and FSM state encoding for mem_access_ctrl.
// Wait-state support is compiled in with MEMCTRL_WAIT_EN.
package mem_access_ctrl_pkg;

  localparam int ADLINES    = 8;
  localparam int DATALINES  = 16;
  localparam int WAITCYCLES = 2;
  localparam int WCNT_W     = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_ACCESS = 3'd2,
    S_WAIT   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  function automatic logic [WCNT_W-1:0] wait_load(input int n);
    return WCNT_W'(n);
  endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Down-counter for ACCESS wait states; only built with MEMCTRL_WAIT_EN.
module mem_wait_counter
  import mem_access_ctrl_pkg::*;
#(
  parameter int W = WCNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic         i_dec,
  input  logic [W-1:0] i_value,
  output logic [W-1:0] o_count,
  output logic         o_last
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_last  = (r_count <= W'(1));

endmodule

// File: rtl/mem_access_ctrl.sv
// CPU-to-RAMblock access sequencer: IDLE/SETUP/ACCESS/(WAIT)/DONE.
// Define MEMCTRL_WAIT_EN to add waitcycles extra ACCESS cycles.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int adlines    = ADLINES,
  parameter int datalines  = DATALINES,
  parameter int waitcycles = WAITCYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req,
  input  logic                 we,
  input  logic [adlines-1:0]   addr,
  input  logic [datalines-1:0] wdata,
  output logic [datalines-1:0] rdata,
  output logic                 ack,
  output logic                 busy,
  output logic [adlines-1:0]   ram_address,
  output logic [datalines-1:0] ram_datain,
  output logic                 ram_read,
  output logic                 ram_write,
  input  logic [datalines-1:0] ram_dataout
);

  if (waitcycles < 0 || waitcycles > 15) begin : g_bad_wait
    $error("waitcycles must be 0..15");
  end

  state_t                 r_state;
  logic [adlines-1:0]     r_addr;
  logic [datalines-1:0]   r_wdata;
  logic                   r_we;
  logic [datalines-1:0]   r_rdata;
  logic                   r_ack;
  logic                   r_busy;
  logic                   r_read;
  logic                   r_write;
  logic                   w_finish;

`ifdef MEMCTRL_WAIT_EN
  localparam logic [WCNT_W-1:0] LP_WAIT = wait_load(waitcycles);

  logic [WCNT_W-1:0] w_count;
  logic              w_last;
  logic              w_load;
  logic              w_dec;

  assign w_load = (r_state == S_ACCESS);
  assign w_dec  = (r_state == S_WAIT);

  mem_wait_counter #(
    .W (WCNT_W)
  ) u_wait (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_dec   (w_dec),
    .i_value (LP_WAIT),
    .o_count (w_count),
    .o_last  (w_last)
  );

  // count==1 in WAIT means this cycle takes it to zero
  assign w_finish =
    ((r_state == S_ACCESS) && (LP_WAIT == '0)) ||
    ((r_state == S_WAIT) && w_last && (w_count != '0));
`else
  assign w_finish = (r_state == S_ACCESS);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_rdata <= '0;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
      r_read  <= 1'b0;
      r_write <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (req) begin
            r_state <= S_SETUP;
            r_busy  <= 1'b1;
            r_addr  <= addr;
            r_wdata <= wdata;
            r_we    <= we;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_SETUP: begin
          r_state <= S_ACCESS;
          r_read  <= ~r_we;
          r_write <= r_we;
        end
        S_ACCESS, S_WAIT: begin
          if (w_finish) begin
            r_state <= S_DONE;
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_ack   <= 1'b1;
            if (!r_we) begin
              r_rdata <= ram_dataout;
            end
          end else begin
            r_state <= S_WAIT;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_read  <= 1'b0;
          r_write <= 1'b0;
        end
      endcase
    end
  end

  assign rdata       = r_rdata;
  assign ack         = r_ack;
  assign busy        = r_busy;
  assign ram_address = r_addr;
  assign ram_datain  = r_wdata;
  assign ram_read    = r_read;
  assign ram_write   = r_write;

endmodule
